// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus bundle for the memory-mapped UART transmitter.
// The CPU drives write data, address and write enable. The peripheral returns read data.
`timescale 1ns/1ps
interface uart_tx_mmio_if;
  logic [31:0] Dataout;
  logic [31:0] address;
  logic        WE;
  wire  [31:0] Datain;

  modport master (output Dataout, output address, output WE, input Datain);
  modport slave  (input Dataout, input address, input WE, output Datain);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a ctrl/status word and a data byte register.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_tx_mmio #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] ADDR_CTRL = 32'h110,
  parameter logic [31:0] ADDR_DATA = 32'h114
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam int unsigned DIV      = CLK_HZ / BAUD;
  localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             send_q, send_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic baud_end_c;
  logic wr_ctrl_c;
  logic wr_data_c;
  logic unused_c;

  assign baud_end_c = (baud_q == CNT_LAST);
  assign wr_ctrl_c  = bus.WE && (bus.address == ADDR_CTRL);
  assign wr_data_c  = bus.WE && (bus.address == ADDR_DATA);
  assign unused_c   = ^bus.Dataout[31:8];

  // Combinational read mux. The bus floats when neither register is addressed.
  assign bus.Datain = (bus.address == ADDR_CTRL) ? {29'd0, busy_q, done_q, send_q} :
                      (bus.address == ADDR_DATA) ? {24'd0, data_q} :
                      32'bz;

  assign tx = tx_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (send_q) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (baud_end_c) state_d = S_DATA;
      S_DATA: begin
        if (baud_end_c && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_end_c) state_d = S_STOP;
`endif
      S_STOP:  if (baud_end_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, register-file and line next values
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    send_d  = send_q;
    done_d  = done_q;
    busy_d  = busy_q;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_LOAD) || baud_end_c) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end

    // CPU writes first so that hardware updates below take priority.
    if (wr_ctrl_c && !busy_q) begin
      send_d = bus.Dataout[0];
      done_d = bus.Dataout[1];
    end
    if (wr_data_c) begin
      data_d = bus.Dataout[7:0];
    end

    unique case (state_q)
      S_LOAD: begin
        shift_d = data_q;
        bit_d   = 3'd0;
        send_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = ^data_q;
`endif
      end
      S_DATA: begin
        if (baud_end_c) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_end_c) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase

    // The line level is registered and follows the state being entered.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      send_q  <= 1'b0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      send_q  <= send_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the same CPU data bus as the interval-timer peripheral at 0x10C. It occupies the next two word addresses: a control/status register at 0x110 and a data register at 0x114. Firmware writes a byte, sets the start bit, and then polls the done bit, using the same start/done protocol as the timer. The serial line is driven out of the FPGA pin `tx`.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_HZ / BAUD` uses integer truncation, giving 10416 at the defaults.
- `ADDR_CTRL`, default 32'h110: control/status register address.
- `ADDR_DATA`, default 32'h114: data register address.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `Dataout`, input, 32: CPU write data.
- `address`, input, 32: CPU byte address.
- `WE`, input, 1: CPU write enable. A write takes effect at the rising edge where `WE`=1.
- `Datain`, output, 32: read data. High-Z when `address` matches neither register.
- `tx`, output, 1: serial line, idle high.

## Operation
- Control register `ctrl` (ADDR_CTRL):
  - bit0 `send`: CPU writes 1 to request a frame.
  - bit1 `done`: set by hardware when a frame completes.
  - bit2 `busy`: read-only.
  - bits[31:3]: read as 0.
- Data register `data` (ADDR_DATA):
  - bits[7:0] hold the byte to send. Bits[31:8] are not stored.
  - Reads return {24'b0, data}.
- Read path: combinational. `Datain` = `ctrl` when `address` == ADDR_CTRL, {24'b0, data} when `address` == ADDR_DATA, otherwise 32'bz.
- State machine `IDLE` → `LOAD` → `START` → `DATA` → `STOP` → `IDLE`:
  - `IDLE`: `tx`=1. Moves to `LOAD` when `send`=1.
  - `LOAD` (1 cycle): copies `data` into an 8-bit shift register, clears `send` and `done`, sets `busy`.
  - `START`: `tx`=0 for DIV cycles.
  - `DATA`: sends 8 bits, LSB first, each held for DIV cycles. A 3-bit bit index counts 0..7.
  - `STOP`: `tx`=1 for DIV cycles. At its last cycle the state goes to `IDLE`, `done` is set and `busy` is cleared.
- Baud counter:
  - Counts 0..DIV-1.
  - Clears on every state entry.
  - When it reaches DIV-1, the current bit ends.
- CPU writes to ADDR_CTRL:
  - While `busy`=0, bits[1:0] are loaded from `Dataout`.
  - While `busy`=1, the write is ignored; no queued frames.
  - Bit2 is never writable.
- CPU writes to ADDR_DATA are accepted at any time. A frame in progress is unaffected because the byte was copied into the shift register in `LOAD`.
- Simultaneous events: if a CPU write and a hardware update of `ctrl` land in the same cycle, the hardware update wins on every bit it drives.
- Reset (`rst`=0 at a rising edge):
  - State goes to `IDLE`, `tx`=1, counters to 0, `data`=0.
  - `ctrl` = 32'h2 (`done`=1: transmitter ready).
  - Reset in mid-frame aborts the frame; `tx` is 1 from the next edge.

## Timing
- Let the CPU write with `send`=1 occur at edge N.
  - Edge N+1: enter `LOAD`.
  - Edge N+2: enter `START`. `tx` falls after edge N+2.
  - First `tx` edge appears 2 cycles after the write.
- Frame length: 10·DIV cycles from `tx` falling to the end of the stop bit (11·DIV with parity).
- `done` reads 1 starting the cycle after the last stop-bit cycle.
- `busy` is 1 from edge N+2 until that same edge.
- No throughput limit other than one frame at a time. Back-to-back frames are separated by at least 2 idle cycles (`IDLE` + `LOAD`).

## Configuration
- `UART_TX_PARITY_EN` defined: a `PARITY` state is inserted between `DATA` and `STOP`.
  - It sends even parity: XOR of the 8 data bits, held for DIV cycles.
  - Frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: no parity state. Frame is 8N1, 10 bits.

## Test plan
Use `CLK_HZ`=1_000_000 and `BAUD`=100_000, so DIV=10.
- Reset: drive `rst`=0 for 2 cycles, then read 0x110 → `Datain`=32'h2, `tx`=1. Read 0x200 → `Datain`=32'bz.
- Basic frame: write 0x114 ← 32'h0000_00A5, then write 0x110 ← 1.
  - `tx` falls 2 cycles after the write.
  - Sampled every 10 cycles, `tx` reads 0,1,0,1,0,0,1,0,1,1.
  - Then 0x110 reads 32'h2.
- Busy lockout: start a frame of 8'h55, then write 0x110 ← 1 at cycle 30.
  - Only one frame is sent.
  - Mid-frame, 0x110 reads 32'h4; after the frame it reads 32'h2.
- Data write mid-frame: during a frame of 8'h0F, write 0x114 ← 8'hF0.
  - The line still carries 8'h0F.
  - 0x114 reads 32'hF0.
- Reset mid-frame: assert `rst`=0 during bit 3.
  - `tx`=1 from the next edge.
  - 0x110 reads 32'h2.
  - No further line transitions.
- Parity build (`UART_TX_PARITY_EN`): send 8'h07.
  - Parity bit = 1.
  - Stop bit ends 110 cycles after `tx` falls.
